// File: rtl/envelope_arbiter_if.sv
// Envelope handshake and FIFO write bundle.
// master = arbiter side, slave = sensors/FIFO side.
interface envelope_arbiter_if #(
    parameter int NUM_SENSORS = 4
);
    logic [32*NUM_SENSORS-1:0] env_timestamp;
    logic [16*NUM_SENSORS-1:0] env_length;
    logic [NUM_SENSORS-1:0]    env_valid;
    logic [NUM_SENSORS-1:0]    env_ready;
    logic [47:0]               fifo_data;
    logic                      fifo_write;
    logic                      fifo_full;

    modport master (
        input  env_timestamp,
        input  env_length,
        input  env_valid,
        input  fifo_full,
        output env_ready,
        output fifo_data,
        output fifo_write
    );

    modport slave (
        output env_timestamp,
        output env_length,
        output env_valid,
        output fifo_full,
        input  env_ready,
        input  fifo_data,
        input  fifo_write
    );
endinterface

// File: rtl/envelope_arbiter.sv
// Round-robin envelope FIFO arbiter plus
// sequential sensor reconfiguration sweep.
module envelope_arbiter #(
    parameter int NUM_SENSORS = 4,
    parameter int HOLD_CYCLES = 48,
    parameter int TIMEOUT_W   = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    envelope_arbiter_if.master     bus,
    input  logic                   cfg_start,
    input  logic [NUM_SENSORS-1:0] sensor_configured,
    output logic [NUM_SENSORS-1:0] sensor_reconfigure,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic [NUM_SENSORS-1:0] cfg_error
);
    localparam int PW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [2:0] {
        CFG_IDLE,
        CFG_ASSERT,
        CFG_WAIT,
        CFG_NEXT,
        CFG_DONE
    } cfg_state_t;

    logic [NUM_SENSORS-1:0] last_grant;
    logic [NUM_SENSORS-1:0] cand;
    logic [NUM_SENSORS-1:0] grant_vec;
    logic [PW-1:0]          ptr;
    logic [PW-1:0]          grant_idx;
    logic [PW-1:0]          ptr_next;
    logic [PW-1:0]          jj;
    logic                   grant_any;

    // Search from the pointer, skipping last cycle's winner.
    always_comb begin
        cand      = bus.env_valid & ~last_grant;
        grant_idx = '0;
        grant_any = 1'b0;
        jj        = '0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            jj = PW'((int'(ptr) + k) % NUM_SENSORS);
            if (!grant_any && cand[jj]) begin
                grant_any = 1'b1;
                grant_idx = jj;
            end
        end
        grant_any = grant_any & ~bus.fifo_full;
        grant_vec = '0;
        if (grant_any)
            grant_vec[grant_idx] = 1'b1;
        if (grant_idx == PW'(NUM_SENSORS - 1))
            ptr_next = '0;
        else
            ptr_next = grant_idx + 1'b1;
    end

    assign bus.env_ready = rst ? '0 : grant_vec;

    // Register the granted record and advance the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fifo_write <= 1'b0;
            bus.fifo_data  <= '0;
            ptr            <= '0;
            last_grant     <= '0;
        end else begin
            bus.fifo_write <= grant_any;
            last_grant     <= grant_vec;
            if (grant_any) begin
                bus.fifo_data <= {
                    bus.env_timestamp[32*int'(grant_idx) +: 32],
                    bus.env_length[16*int'(grant_idx) +: 16]
                };
                ptr <= ptr_next;
            end
        end
    end

    cfg_state_t             state, state_n;
    logic [PW-1:0]          idx, idx_n;
    logic [HW-1:0]          hold_cnt, hold_cnt_n;
    logic [TIMEOUT_W-1:0]   to_cnt, to_cnt_n;
    logic                   busy_n, done_n;
    logic [NUM_SENSORS-1:0] err_n;

    // Configuration sweep state and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CFG_IDLE;
            idx       <= '0;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            cfg_busy  <= 1'b0;
            cfg_done  <= 1'b0;
            cfg_error <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            hold_cnt  <= hold_cnt_n;
            to_cnt    <= to_cnt_n;
            cfg_busy  <= busy_n;
            cfg_done  <= done_n;
            cfg_error <= err_n;
        end
    end

    // Next-state logic for the sweep.
    always_comb begin
        state_n    = state;
        idx_n      = idx;
        hold_cnt_n = hold_cnt;
        to_cnt_n   = to_cnt;
        busy_n     = cfg_busy;
        done_n     = cfg_done;
        err_n      = cfg_error;
        unique case (state)
            CFG_IDLE: begin
                if (cfg_start) begin
                    idx_n      = '0;
                    done_n     = 1'b0;
                    err_n      = '0;
                    busy_n     = 1'b1;
                    hold_cnt_n = '0;
                    state_n    = CFG_ASSERT;
                end
            end
            CFG_ASSERT: begin
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    to_cnt_n = '0;
                    state_n  = CFG_WAIT;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            CFG_WAIT: begin
                // A late configured flag beats a simultaneous timeout.
                if (sensor_configured[idx]) begin
                    state_n = CFG_NEXT;
                end else if (&to_cnt) begin
                    err_n[idx] = 1'b1;
                    state_n    = CFG_NEXT;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            CFG_NEXT: begin
                if (idx == PW'(NUM_SENSORS - 1)) begin
                    state_n = CFG_DONE;
                end else begin
                    idx_n      = idx + 1'b1;
                    hold_cnt_n = '0;
                    state_n    = CFG_ASSERT;
                end
            end
            CFG_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = CFG_IDLE;
            end
            default: state_n = CFG_IDLE;
        endcase
    end

    // Decoded from state so reset drops it at once.
    always_comb begin
        sensor_reconfigure = '0;
        if (state == CFG_ASSERT || state == CFG_WAIT)
            sensor_reconfigure[idx] = 1'b1;
    end
endmodule

// File: tb/tb_envelope_arbiter.sv
// Directed bench for envelope_arbiter: arbitration,
// backpressure, config sweep, timeout and async reset.
module tb_envelope_arbiter;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         cfg_start;
    logic [N-1:0] sensor_configured = '0;
    logic [N-1:0] sensor_reconfigure;
    logic         cfg_busy;
    logic         cfg_done;
    logic [N-1:0] cfg_error;

    envelope_arbiter_if #(.NUM_SENSORS(N)) bus ();

    envelope_arbiter #(
        .NUM_SENSORS(N),
        .HOLD_CYCLES(48),
        .TIMEOUT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .cfg_start(cfg_start),
        .sensor_configured(sensor_configured),
        .sensor_reconfigure(sensor_reconfigure),
        .cfg_busy(cfg_busy),
        .cfg_done(cfg_done),
        .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rec(input int i, input logic [31:0] ts,
                           input logic [15:0] len);
        bus.env_timestamp[32*i +: 32] = ts;
        bus.env_length[16*i +: 16]    = len;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Sensor model: configured 100 cycles after a reconfigure rise.
    logic [N-1:0] en = '1;
    initial begin
        int cnt [N];
        logic [N-1:0] rprev;
        logic [N-1:0] flags;
        rprev = '0;
        flags = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (sensor_reconfigure[i] && !rprev[i]) begin
                    cnt[i]   = 0;
                    flags[i] = 1'b0;
                end else if (sensor_reconfigure[i]) begin
                    cnt[i]++;
                    if (cnt[i] == 100 && en[i]) flags[i] = 1'b1;
                end
            end
            rprev = sensor_reconfigure;
            sensor_configured = flags;
        end
    end

    // Reconfigure monitor: rise order, high time, exclusivity.
    int rise_q [$];
    int min_high = 1000000;
    bit viol = 1'b0;
    initial begin
        int hcnt [N];
        logic [N-1:0] prev;
        prev = '0;
        for (int i = 0; i < N; i++) hcnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (sensor_reconfigure[i] && !prev[i]) begin
                    rise_q.push_back(i);
                    hcnt[i] = 0;
                end
                if (sensor_reconfigure[i]) hcnt[i]++;
                if (!sensor_reconfigure[i] && prev[i] && hcnt[i] < min_high)
                    min_high = hcnt[i];
            end
            if ($countones(sensor_reconfigure) > 1) viol = 1'b1;
            prev = sensor_reconfigure;
        end
    end

    initial begin
        int hold_off [N];
        logic [31:0] wq [$];
        logic [N-1:0] rd;
        bit bad;
        int base;

        rst = 1'b1;
        cfg_start = 1'b0;
        bus.env_valid = '0;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < N; i++)
            set_rec(i, 32'h1000_0000 + i, 16'h00A0 + 16'(i));

        #2;
        chk("rst_fifo_write", 64'(bus.fifo_write), 64'd0);
        chk("rst_fifo_data", 64'(bus.fifo_data), 64'd0);
        chk("rst_reconfig", 64'(sensor_reconfigure), 64'd0);
        chk("rst_busy", 64'(cfg_busy), 64'd0);
        chk("rst_done", 64'(cfg_done), 64'd0);
        chk("rst_error", 64'(cfg_error), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single channel grant and 1-cycle write latency.
        @(negedge clk);
        set_rec(2, 32'h4000_1234, 16'h0100);
        bus.env_valid = 4'b0100;
        #1 chk("single_ready", 64'(bus.env_ready), 64'b0100);
        @(negedge clk);
        bus.env_valid = '0;
        chk("single_write", 64'(bus.fifo_write), 64'd1);
        chk("single_data", 64'(bus.fifo_data), 64'h4000_1234_0100);
        #1 chk("single_ready_off", 64'(bus.env_ready), 64'd0);
        @(negedge clk);
        chk("single_write_off", 64'(bus.fifo_write), 64'd0);
        set_rec(2, 32'h1000_0002, 16'h00A2);

        // Round-robin with drop and re-raise two cycles later.
        do_reset();
        for (int i = 0; i < N; i++) hold_off[i] = 0;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.fifo_write) wq.push_back(bus.fifo_data[47:16]);
            for (int i = 0; i < N; i++) begin
                bus.env_valid[i] = (hold_off[i] == 0);
                if (hold_off[i] > 0) hold_off[i]--;
            end
            #1;
            rd = bus.env_ready;
            if ($countones(rd) > 1) bad = 1'b1;
            for (int i = 0; i < N; i++)
                if (rd[i]) hold_off[i] = 2;
            @(negedge clk);
        end
        bus.env_valid = '0;
        chk("rr_onehot", 64'(bad), 64'd0);
        chk("rr_write_count_ge8", 64'(wq.size() >= 8), 64'd1);
        if (wq.size() >= 8)
            for (int k = 0; k < 8; k++)
                chk($sformatf("rr_order_%0d", k), 64'(wq[k]),
                    64'(32'h1000_0000 + (k % 4)));

        // Backpressure then drain in pointer order.
        do_reset();
        bus.fifo_full = 1'b1;
        bus.env_valid = 4'b1001;
        bad = 1'b0;
        repeat (10) begin
            #1;
            if (bus.env_ready !== '0 || bus.fifo_write !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        chk("bp_stall", 64'(bad), 64'd0);
        bus.fifo_full = 1'b0;
        #1 chk("bp_ready_ch0", 64'(bus.env_ready), 64'b0001);
        @(negedge clk);
        bus.env_valid = 4'b1000;
        chk("bp_write_ch0", 64'(bus.fifo_write), 64'd1);
        chk("bp_data_ch0", 64'(bus.fifo_data), 64'h1000_0000_00A0);
        #1 chk("bp_ready_ch3", 64'(bus.env_ready), 64'b1000);
        @(negedge clk);
        bus.env_valid = '0;
        chk("bp_write_ch3", 64'(bus.fifo_write), 64'd1);
        chk("bp_data_ch3", 64'(bus.fifo_data), 64'h1000_0003_00A3);

        // Full configuration sweep, all sensors respond.
        do_reset();
        en = 4'b1111;
        base = rise_q.size();
        min_high = 1000000;
        viol = 1'b0;
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("sweep_busy", 64'(cfg_busy), 64'd1);
        chk("sweep_first", 64'(sensor_reconfigure), 64'b0001);
        for (int k = 0; k < 3000 && !cfg_done; k++) @(negedge clk);
        chk("sweep_done", 64'(cfg_done), 64'd1);
        chk("sweep_error", 64'(cfg_error), 64'd0);
        chk("sweep_busy_off", 64'(cfg_busy), 64'd0);
        chk("sweep_rises", 64'(rise_q.size() - base), 64'd4);
        if (rise_q.size() - base == 4)
            for (int k = 0; k < 4; k++)
                chk($sformatf("sweep_rise_%0d", k), 64'(rise_q[base+k]),
                    64'(k));
        chk("sweep_min_hold", 64'(min_high >= 48), 64'd1);
        chk("sweep_onehot", 64'(viol), 64'd0);

        // Channel 1 never configures: timeout after 256 cycles.
        do_reset();
        en = 4'b1101;
        base = rise_q.size();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int k = 0; k < 4000 && !cfg_done; k++) @(negedge clk);
        chk("to_done", 64'(cfg_done), 64'd1);
        chk("to_error", 64'(cfg_error), 64'b0010);
        chk("to_rises", 64'(rise_q.size() - base), 64'd4);
        chk("to_onehot", 64'(viol), 64'd0);

        // Async reset while waiting on channel 2.
        do_reset();
        en = 4'b1111;
        base = rise_q.size();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int k = 0; k < 2000 && rise_q.size() - base < 3; k++)
            @(negedge clk);
        repeat (60) @(negedge clk);
        chk("ar_wait_ch2", 64'(sensor_reconfigure), 64'b0100);
        bus.env_valid = 4'b1111;
        #3 rst = 1'b1;
        #1;
        chk("ar_reconfig", 64'(sensor_reconfigure), 64'd0);
        chk("ar_busy", 64'(cfg_busy), 64'd0);
        chk("ar_ready", 64'(bus.env_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.env_valid = '0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
